// File: rtl/player2_fighter_controller.sv
// Player-2 fighter: position tracking with player-1 gap limiting, and a STARTUP/ACTIVE/RECOVERY attack sequence.
// State updates one tick after its commands; game_active_in=0 freezes position, state and counter.
module player2_fighter_controller #(
   parameter int X_WIDTH         = 10,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = 576,
   parameter int X_INIT          = 400,
   parameter int MOVE_STEP       = 3,
   parameter int MIN_GAP         = 40,
   parameter int STARTUP_FRAMES  = 5,
   parameter int ACTIVE_FRAMES   = 2,
   parameter int RECOVERY_FRAMES = 16
) (
   input  logic               clk_60Hz_game,
   input  logic               reset,
   input  logic               game_active_in,
   input  logic               p2_move_left_cmd_in,
   input  logic               p2_move_right_cmd_in,
   input  logic               p2_attack_cmd_in,
   input  logic [X_WIDTH-1:0] p1_x_in,
   output logic [X_WIDTH-1:0] p2_x_out,
   output logic [2:0]         p2_state_out,
   output logic               p2_hitbox_active_out,
   output logic               p2_attack_start_pulse_out
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_MOVE_L   = 3'd1;
   localparam logic [2:0] ST_MOVE_R   = 3'd2;
   localparam logic [2:0] ST_STARTUP  = 3'd3;
   localparam logic [2:0] ST_ACTIVE   = 3'd4;
   localparam logic [2:0] ST_RECOVERY = 3'd5;

   localparam int MAX_F = (STARTUP_FRAMES > ACTIVE_FRAMES)
                          ? ((STARTUP_FRAMES > RECOVERY_FRAMES) ? STARTUP_FRAMES : RECOVERY_FRAMES)
                          : ((ACTIVE_FRAMES > RECOVERY_FRAMES) ? ACTIVE_FRAMES : RECOVERY_FRAMES);
   localparam int CNT_W = (MAX_F > 1) ? $clog2(MAX_F) : 1;
   localparam int XW1   = X_WIDTH + 1;

   logic [X_WIDTH-1:0] x_q, x_d;
   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               att_prev_q, att_prev_d;
   logic               pulse_q, pulse_d;

   logic               att_edge;
   logic [XW1-1:0]     x_ext, floor_ext, dec_ext, left_ext, inc_ext, right_ext;

   // One extra bit keeps p1_x+MIN_GAP and x+MOVE_STEP from wrapping before the clamps.
   always_comb begin
      x_ext     = {1'b0, x_q};
      floor_ext = {1'b0, p1_x_in} + XW1'(MIN_GAP);
      dec_ext   = (x_ext >= XW1'(MOVE_STEP)) ? (x_ext - XW1'(MOVE_STEP)) : '0;
      left_ext  = dec_ext;
      if (left_ext < floor_ext) left_ext = floor_ext;
      if (left_ext < XW1'(X_MIN)) left_ext = XW1'(X_MIN);
      inc_ext   = x_ext + XW1'(MOVE_STEP);
      right_ext = (inc_ext > XW1'(X_MAX)) ? XW1'(X_MAX) : inc_ext;
   end

   always_comb begin
      att_edge   = p2_attack_cmd_in & ~att_prev_q;
      att_prev_d = p2_attack_cmd_in;
      x_d        = x_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      pulse_d    = 1'b0;
      if (game_active_in) begin
         case (state_q)
            ST_STARTUP: begin
               if (cnt_q == '0) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = CNT_W'(ACTIVE_FRAMES - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == '0) begin
                  state_d = ST_RECOVERY;
                  cnt_d   = CNT_W'(RECOVERY_FRAMES - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_RECOVERY: begin
               if (cnt_q == '0) state_d = ST_IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
               if (att_edge) begin
                  state_d = ST_STARTUP;
                  cnt_d   = CNT_W'(STARTUP_FRAMES - 1);
                  pulse_d = 1'b1;
               end else if (p2_move_left_cmd_in && p2_move_right_cmd_in) begin
                  state_d = ST_IDLE;
               end else if (p2_move_left_cmd_in) begin
                  state_d = ST_MOVE_L;
                  // Already at or inside the gap: hold, never push right.
                  if (x_ext > floor_ext) x_d = left_ext[X_WIDTH-1:0];
               end else if (p2_move_right_cmd_in) begin
                  state_d = ST_MOVE_R;
                  x_d     = right_ext[X_WIDTH-1:0];
               end else begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_60Hz_game or posedge reset) begin
      if (reset) begin
         x_q        <= X_WIDTH'(X_INIT);
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         att_prev_q <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         x_q        <= x_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         att_prev_q <= att_prev_d;
         pulse_q    <= pulse_d;
      end
   end

   assign p2_x_out                  = x_q;
   assign p2_state_out              = state_q;
   assign p2_attack_start_pulse_out = pulse_q;
   assign p2_hitbox_active_out      = (state_q == ST_ACTIVE) & game_active_in;

endmodule

// File: tb/tb_player2_fighter_controller.sv
// Bench for player2_fighter_controller: vector table, timing sequences and random stimulus vs a tick-age model.
module tb_player2_fighter_controller;

   localparam int S = 5;
   localparam int A = 2;
   localparam int R = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ga = 1'b1;
   logic       l = 1'b0;
   logic       r = 1'b0;
   logic       a = 1'b0;
   logic [9:0] p1 = 10'd100;
   logic [9:0] x_out;
   logic [2:0] st_out;
   logic       hit, pul;

   int total = 0;
   int passed = 0;

   // Reference model: attack tracked as ticks elapsed since launch.
   int m_x = 400;
   int m_move = 0;
   int m_age = 0;
   int m_prev = 0;
   int m_pulse = 0;

   typedef struct {
      logic       ga, l, r, a;
      logic [9:0] p1;
      int         ex, est, ehit, epul;
   } vec_t;
   vec_t tbl[12];

   player2_fighter_controller dut (
      .clk_60Hz_game            (clk),
      .reset                    (reset),
      .game_active_in           (ga),
      .p2_move_left_cmd_in      (l),
      .p2_move_right_cmd_in     (r),
      .p2_attack_cmd_in         (a),
      .p1_x_in                  (p1),
      .p2_x_out                 (x_out),
      .p2_state_out             (st_out),
      .p2_hitbox_active_out     (hit),
      .p2_attack_start_pulse_out(pul)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d required %0d", nm, act, exp);
   endtask

   function automatic int m_state();
      if (m_age == 0)          return m_move;
      else if (m_age <= S)     return 3;
      else if (m_age <= S + A) return 4;
      else                     return 5;
   endfunction

   task automatic model_reset();
      m_x = 400; m_move = 0; m_age = 0; m_prev = 0; m_pulse = 0;
   endtask

   task automatic model_step();
      int edge_v, floor_v, cand;
      edge_v  = (a && m_prev == 0) ? 1 : 0;
      m_prev  = a ? 1 : 0;
      m_pulse = 0;
      if (!ga) return;
      if (m_age > 0) begin
         m_age++;
         if (m_age > S + A + R) begin
            m_age  = 0;
            m_move = 0;
         end
         return;
      end
      if (edge_v == 1) begin
         m_age   = 1;
         m_pulse = 1;
      end else if (l && r) begin
         m_move = 0;
      end else if (l) begin
         m_move  = 1;
         floor_v = int'(p1) + 40;
         if (m_x > floor_v) begin
            cand = m_x - 3;
            if (cand < floor_v) cand = floor_v;
            if (cand < 0) cand = 0;
            m_x = cand;
         end
      end else if (r) begin
         m_move = 2;
         m_x    = (m_x + 3 > 576) ? 576 : m_x + 3;
      end else begin
         m_move = 0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, " x"},      int'(x_out),  m_x);
      check({tag, " state"},  int'(st_out), m_state());
      check({tag, " hitbox"}, int'(hit),    (m_state() == 4 && ga) ? 1 : 0);
      check({tag, " pulse"},  int'(pul),    m_pulse);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check("reset x", int'(x_out), 400);
      check("reset state", int'(st_out), 0);
      check("reset hitbox", int'(hit), 0);
      check("reset pulse", int'(pul), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_in(input logic g, input logic ll, input logic rr, input logic aa, input logic [9:0] pp);
      ga = g; l = ll; r = rr; a = aa; p1 = pp;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 403, 2, 0, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 406, 2, 0, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd100, 406, 0, 0, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd350, 403, 1, 0, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd350, 400, 1, 0, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd380, 400, 1, 0, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd380, 400, 0, 0, 0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 400, 0, 0, 0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd100, 400, 3, 0, 1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd100, 400, 3, 0, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd100, 400, 3, 0, 0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 400, 3, 0, 0};

      // Reset state
      reset = 1'b1;
      #1;
      check("por x", int'(x_out), 400);
      check("por state", int'(st_out), 0);
      check("por hitbox", int'(hit), 0);
      check("por pulse", int'(pul), 0);
      @(negedge clk);
      reset = 1'b0;

      // Vector table
      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].ga, tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].p1);
         tick($sformatf("vec%0d model", i));
         check($sformatf("vec%0d x", i), int'(x_out), tbl[i].ex);
         check($sformatf("vec%0d state", i), int'(st_out), tbl[i].est);
         check($sformatf("vec%0d hitbox", i), int'(hit), tbl[i].ehit);
         check($sformatf("vec%0d pulse", i), int'(pul), tbl[i].epul);
      end

      // Right held: 430 after 10 ticks, clamp at 576
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 10'd100);
      for (int t = 1; t <= 60; t++) begin
         tick($sformatf("right t%0d", t));
         if (t == 10) check("right10 x", int'(x_out), 430);
         if (t == 58) check("right58 x", int'(x_out), 574);
         if (t == 59) check("right59 x", int'(x_out), 576);
         if (t == 60) check("right60 x", int'(x_out), 576);
      end
      check("right state", int'(st_out), 2);

      // Left held against p1 gap
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 10'd350);
      for (int t = 1; t <= 5; t++) begin
         tick($sformatf("left t%0d", t));
         check($sformatf("left gap x t%0d", t), int'(x_out), (t < 4) ? 400 - 3 * t : 390);
      end
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 10'd380);
      tick("overlap");
      check("overlap x", int'(x_out), 400);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 10'd1000);
      tick("p1 overflow");
      check("p1 overflow x", int'(x_out), 400);

      // Attack held 40 ticks
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 10'd100);
      for (int t = 1; t <= 40; t++) begin
         int est;
         est = (t <= 5) ? 3 : (t <= 7) ? 4 : (t <= 23) ? 5 : 0;
         tick($sformatf("atk t%0d", t));
         check($sformatf("atk state t%0d", t), int'(st_out), est);
         check($sformatf("atk pulse t%0d", t), int'(pul), (t == 1) ? 1 : 0);
         check($sformatf("atk hitbox t%0d", t), int'(hit), (est == 4) ? 1 : 0);
      end

      // Freeze during STARTUP, then resume
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 10'd100);
      tick("frz t1");
      tick("frz t2");
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 10'd100);
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) a = 1'b0;
         if (k == 6) a = 1'b1;
         tick($sformatf("frozen k%0d", k));
         check($sformatf("frozen state k%0d", k), int'(st_out), 3);
         check($sformatf("frozen pulse k%0d", k), int'(pul), 0);
         check($sformatf("frozen x k%0d", k), int'(x_out), 400);
      end
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 10'd100);
      for (int k = 1; k <= 22; k++) begin
         int est;
         est = (k <= 3) ? 3 : (k <= 5) ? 4 : (k <= 21) ? 5 : 0;
         tick($sformatf("resume k%0d", k));
         check($sformatf("resume state k%0d", k), int'(st_out), est);
      end

      // Reset mid-ACTIVE, plus hitbox gating by game_active_in
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 10'd100);
      for (int t = 1; t <= 3; t++) tick("pre move");
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 10'd100);
      for (int t = 1; t <= 6; t++) tick($sformatf("to active t%0d", t));
      check("mid active hitbox", int'(hit), 1);
      check("mid active x", int'(x_out), 409);
      ga = 1'b0;
      #1;
      check("hitbox gated", int'(hit), 0);
      ga = 1'b1;
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      check("async reset hitbox", int'(hit), 0);
      check("async reset x", int'(x_out), 400);
      check("async reset state", int'(st_out), 0);
      @(negedge clk);
      reset = 1'b0;
      a = 1'b0;

      // Random stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         int near;
         if ($urandom_range(0, 599) == 0) do_reset();
         ga = ($urandom_range(0, 9) != 0);
         l  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) a = ~a;
         if ($urandom_range(0, 1) == 0) begin
            near = m_x - int'($urandom_range(0, 80));
            p1 = (near < 0) ? 10'd0 : 10'(near);
         end else begin
            p1 = 10'($urandom_range(0, 1023));
         end
         tick($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
